// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters sharing one start/end measurement window.
// Counts are frozen into snapshot registers that software reads through a registered word mux.
module perf_counter_bank #(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 48,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              perf_start,
  input  logic              perf_end,
  input  logic              perf_en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] ch_event,
  input  logic [3:0]        rd_ch_sel,
  input  logic              rd_word_sel,
  output logic [31:0]       rd_data,
  output logic              running,
  output logic              snap_valid,
  output logic [NUM_CH-1:0] ovf_flags
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                        state, state_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0]  live, snap;
  logic [NUM_CH-1:0]             cnt_en;
  logic                          count_ok, take_snap;
  logic [CNT_W-1:0]              rd_sel_cnt;
  logic [63:0]                   rd_sel_ext;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (perf_start) state_nxt = RUN;
      RUN:     if (perf_start) state_nxt = RUN;
               else if (perf_end) state_nxt = DONE;
      DONE:    if (perf_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running    = (state == RUN);
    snap_valid = (state == DONE);
  end

  // Start and end cycles never count; start also beats a coincident end.
  assign count_ok  = (state == RUN) && perf_en && !perf_start && !perf_end;
  assign take_snap = (state == RUN) && perf_end && !perf_start;
  assign cnt_en    = {NUM_CH{count_ok}} & ch_mask & ch_event;

  // NOTE: counter and snapshot arrays are explicitly cleared on reset because
  // stale counts would be visible to software; a plain storage array would not need it.
  always_ff @(posedge clk) begin
    if (rst || perf_start) begin
      live      <= '0;
      snap      <= '0;
      ovf_flags <= '0;
    end else begin
      if (take_snap) snap <= live;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_en[i]) begin
          if (&live[i]) begin
            ovf_flags[i] <= 1'b1;
            if (!SATURATE) live[i] <= '0;
          end else begin
            live[i] <= live[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Out-of-range channels fall through to zero; zero-extension to 64 bits
  // makes the upper word read as 0 when CNT_W <= 32.
  always_comb begin
    rd_sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_sel == 4'(i)) rd_sel_cnt = snap[i];
    end
    rd_sel_ext = 64'(rd_sel_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst)              rd_data <= '0;
    else if (rd_word_sel) rd_data <= rd_sel_ext[63:32];
    else                  rd_data <= rd_sel_ext[31:0];
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 48-bit saturating bank plus 8-bit saturate/wrap banks
// sharing stimulus; read results are checked through an expected-value queue.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst, perf_start, perf_end, perf_en, rd_word_sel;
  logic [7:0]  ch_mask, ch_event;
  logic [3:0]  rd_ch_sel;
  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic        running0, running1, running2;
  logic        snap_valid0, snap_valid1, snap_valid2;
  logic [7:0]  ovf0, ovf1, ovf2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0][47:0] preload;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(8), .CNT_W(48), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .perf_start(perf_start), .perf_end(perf_end), .perf_en(perf_en),
    .ch_mask(ch_mask), .ch_event(ch_event), .rd_ch_sel(rd_ch_sel), .rd_word_sel(rd_word_sel),
    .rd_data(rd_data0), .running(running0), .snap_valid(snap_valid0), .ovf_flags(ovf0));

  perf_counter_bank #(.NUM_CH(8), .CNT_W(8), .SATURATE(1'b1)) dut_sat8 (
    .clk(clk), .rst(rst), .perf_start(perf_start), .perf_end(perf_end), .perf_en(perf_en),
    .ch_mask(ch_mask), .ch_event(ch_event), .rd_ch_sel(rd_ch_sel), .rd_word_sel(rd_word_sel),
    .rd_data(rd_data1), .running(running1), .snap_valid(snap_valid1), .ovf_flags(ovf1));

  perf_counter_bank #(.NUM_CH(8), .CNT_W(8), .SATURATE(1'b0)) dut_wrap8 (
    .clk(clk), .rst(rst), .perf_start(perf_start), .perf_end(perf_end), .perf_en(perf_en),
    .ch_mask(ch_mask), .ch_event(ch_event), .rd_ch_sel(rd_ch_sel), .rd_word_sel(rd_word_sel),
    .rd_data(rd_data2), .running(running2), .snap_valid(snap_valid2), .ovf_flags(ovf2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pulse_start();
    perf_start = 1'b1; tick(); perf_start = 1'b0;
  endtask

  task automatic pulse_end();
    perf_end = 1'b1; tick(); perf_end = 1'b0;
  endtask

  // Expected value is queued when the select is driven and popped once rd_data has registered it.
  task automatic rd(input int inst, input logic [3:0] ch, input logic word,
                    input logic [31:0] expv, input string tag);
    logic [31:0] got;
    rd_ch_sel = ch;
    rd_word_sel = word;
    exp_q.push_back(expv);
    tick();
    got = (inst == 0) ? rd_data0 : (inst == 1) ? rd_data1 : rd_data2;
    check(got, exp_q.pop_front(), tag);
  endtask

  initial begin
    rst = 1'b1; perf_start = 1'b0; perf_end = 1'b0; perf_en = 1'b0;
    ch_mask = '0; ch_event = '0; rd_ch_sel = '0; rd_word_sel = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check(32'(running0), 0, "reset_running");
    check(32'(snap_valid0), 0, "reset_snap_valid");
    check(32'(ovf0), 0, "reset_ovf");
    check(rd_data0, 0, "reset_rd_data");

    // 100 events on ch0
    pulse_start();
    perf_en = 1'b1; ch_mask = 8'hFF; ch_event = 8'h01;
    repeat (100) tick();
    ch_event = 8'h00;
    pulse_end();
    check(32'(running0), 0, "done_running");
    check(32'(snap_valid0), 1, "done_snap_valid");
    rd(0, 4'd0, 1'b0, 32'd100, "ch0_100");
    rd(0, 4'd1, 1'b0, 32'd0, "ch1_idle");

    // masked channels with perf_en dropped for 3 of 10 cycles
    pulse_start();
    ch_mask = 8'h05; ch_event = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      perf_en = !(i >= 3 && i <= 5);
      tick();
    end
    perf_en = 1'b1; ch_event = 8'h00;
    pulse_end();
    rd(0, 4'd0, 1'b0, 32'd7, "mask_ch0");
    rd(0, 4'd2, 1'b0, 32'd7, "mask_ch2");
    rd(0, 4'd1, 1'b0, 32'd0, "mask_ch1");
    rd(0, 4'd7, 1'b0, 32'd0, "mask_ch7");
    check(32'(ovf0), 0, "mask_ovf");

    // 300 events on ch1: 8-bit banks overflow, 48-bit bank does not
    pulse_start();
    ch_mask = 8'hFF; ch_event = 8'h02;
    repeat (300) tick();
    ch_event = 8'h00;
    pulse_end();
    rd(0, 4'd1, 1'b0, 32'd300, "w48_ch1_300");
    rd(1, 4'd1, 1'b0, 32'd255, "sat8_ch1");
    rd(2, 4'd1, 1'b0, 32'd44, "wrap8_ch1");
    rd(1, 4'd1, 1'b1, 32'd0, "sat8_word1");
    check(32'(ovf0), 0, "w48_ovf");
    check(32'(ovf1), 32'h02, "sat8_ovf");
    check(32'(ovf2), 32'h02, "wrap8_ovf");
    check({28'd0, running1, snap_valid1, running2, snap_valid2}, 32'h5, "small_state");

    // start and end together in RUN: restart wins, end-cycle event excluded
    pulse_start();
    ch_event = 8'h01;
    repeat (5) tick();
    ch_event = 8'h00;
    perf_start = 1'b1; perf_end = 1'b1; tick();
    perf_start = 1'b0; perf_end = 1'b0;
    check(32'(running0), 1, "both_running");
    check(32'(snap_valid0), 0, "both_snap_valid");
    rd(0, 4'd0, 1'b0, 32'd0, "both_snap_zero");
    ch_event = 8'h01;
    repeat (4) tick();
    ch_event = 8'hFF;
    pulse_end();
    ch_event = 8'h00;
    rd(0, 4'd0, 1'b0, 32'd4, "end_excl_ch0");
    rd(0, 4'd1, 1'b0, 32'd0, "end_excl_ch1");
    ch_event = 8'hFF;
    pulse_end();
    ch_event = 8'h00;
    rd(0, 4'd0, 1'b0, 32'd4, "end_in_done");
    check(32'(snap_valid0), 1, "end_in_done_valid");

    // 48-bit word split with a preloaded live count of 2^33+5
    pulse_start();
    preload = '0;
    preload[0] = 48'h2_0000_0005;
    force dut.live = preload;
    tick();
    pulse_end();
    release dut.live;
    rd(0, 4'd0, 1'b0, 32'd5, "split_word0");
    rd(0, 4'd0, 1'b1, 32'd2, "split_word1");
    rd(0, 4'd9, 1'b0, 32'd0, "oob_ch9_w0");
    rd(0, 4'd9, 1'b1, 32'd0, "oob_ch9_w1");

    // reset mid-window, then end in IDLE is ignored
    rd_ch_sel = 4'd0; rd_word_sel = 1'b0;
    pulse_start();
    ch_event = 8'h01;
    repeat (50) tick();
    ch_event = 8'h00;
    rst = 1'b1; tick(); rst = 1'b0;
    check(32'(running0), 0, "rst_mid_running");
    check(32'(snap_valid0), 0, "rst_mid_snap_valid");
    check(32'(ovf0), 0, "rst_mid_ovf");
    check(rd_data0, 0, "rst_mid_rd_data");
    pulse_end();
    check(32'(snap_valid0), 0, "idle_end_snap_valid");
    check(32'(running0), 0, "idle_end_running");
    rd(0, 4'd0, 1'b0, 32'd0, "idle_end_ch0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
